poly_add_mod: RTL

- Stage directly downstream of the ping-pong polynomial multiplier in the FV encryption datapath.
- Consumes the product stream z (one coefficient per cycle) and an error/message polynomial stream e.
- Emits c = (z + e) mod Q coefficient-wise on an AXI stream, with framing checks and sticky error flags.
- Sits between multiplier_top and the ciphertext output packer.

---
 rtl/fv_pkg.sv | 18 +
 rtl/axis_join2.sv | 18 +
 rtl/poly_add_mod.sv | 101 ++++++++++
 3 files changed

// File: rtl/fv_pkg.sv
// Shared types and helpers for the FV encryption datapath.
// Coefficient types are sized for the widest supported QW; narrower blocks zero-extend.
package fv_pkg;

    localparam int                    QW_DEFAULT = 64;
    localparam logic [QW_DEFAULT-1:0] Q_DEFAULT  = 64'hFFFF_FFFF_0000_0001;

    typedef logic [QW_DEFAULT-1:0] coeff_t;
    typedef logic [QW_DEFAULT:0]   coeff_sum_t;

    // Single conditional subtract; valid whenever sum < 2*q.
    function automatic coeff_t mod_sub_q(input coeff_sum_t sum, input coeff_t q);
        coeff_sum_t q_ext;
        q_ext = {1'b0, q};
        return (sum >= q_ext) ? coeff_t'(sum - q_ext) : coeff_t'(sum);
    endfunction

endpackage

// File: rtl/axis_join2.sv
// Two-input AXI-stream join: each side is ready only when the other side is valid,
// so a pair is always consumed together.
module axis_join2 (
    input  logic i_en,
    input  logic i_a_vld,
    input  logic i_b_vld,
    output logic o_a_rdy,
    output logic o_b_rdy,
    output logic o_accept
);

    always_comb begin
        o_a_rdy  = i_en && i_b_vld;
        o_b_rdy  = i_en && i_a_vld;
        o_accept = i_en && i_a_vld && i_b_vld;
    end

endmodule

// File: rtl/poly_add_mod.sv
// c = (z + e) mod Q, coefficient-wise, as a two-stage pipeline with counter-derived framing
// and sticky framing/range error flags.
module poly_add_mod
    import fv_pkg::*;
#(
    parameter int             N  = 16,
    parameter int             QW = 64,
    parameter logic [QW-1:0]  Q  = QW'(Q_DEFAULT)
) (
    input  logic          clk,
    input  logic          s_rst,
    input  logic [QW-1:0] i_z_data,
    input  logic          i_z_vld,
    input  logic          i_z_last,
    output logic          o_z_rdy,
    input  logic [QW-1:0] i_e_data,
    input  logic          i_e_vld,
    input  logic          i_e_last,
    output logic          o_e_rdy,
    output logic [QW-1:0] o_c_data,
    output logic          o_c_vld,
    output logic          o_c_last,
    input  logic          i_c_rdy,
    output logic          o_err_frame,
    output logic          o_err_range,
    output logic          o_poly_done
);

    localparam int             CW       = $clog2(N);
    localparam logic [CW-1:0]  LAST_IDX = CW'(N - 1);

    logic          w_en;
    logic          w_accept;
    logic          w_cnt_last;
    logic          w_range_bad;
    logic [QW-1:0] w_mod;

    logic [CW-1:0] r_cnt;
    logic          r_s1_vld;
    logic          r_s1_last;
    logic [QW:0]   r_s1_sum;

    // Global stall: both stages move together whenever the output slot can take data.
    always_comb begin
        w_en        = !o_c_vld || i_c_rdy;
        w_cnt_last  = (r_cnt == LAST_IDX);
        w_range_bad = (i_z_data >= Q) || (i_e_data >= Q);
        w_mod       = QW'(mod_sub_q(coeff_sum_t'(r_s1_sum), coeff_t'(Q)));
    end

    axis_join2 u_join (
        .i_en     (w_en),
        .i_a_vld  (i_z_vld),
        .i_b_vld  (i_e_vld),
        .o_a_rdy  (o_z_rdy),
        .o_b_rdy  (o_e_rdy),
        .o_accept (w_accept)
    );

    always_ff @(posedge clk) begin
        if (s_rst) begin
            r_cnt       <= '0;
            r_s1_vld    <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_sum    <= '0;
            o_c_vld     <= 1'b0;
            o_c_last    <= 1'b0;
            o_c_data    <= '0;
            o_err_frame <= 1'b0;
            o_err_range <= 1'b0;
            o_poly_done <= 1'b0;
        end else begin
            o_poly_done <= o_c_vld && i_c_rdy && o_c_last;

            if (w_accept) begin
                r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
                if ((i_z_last != w_cnt_last) || (i_e_last != w_cnt_last))
                    o_err_frame <= 1'b1;
                if (w_range_bad)
                    o_err_range <= 1'b1;
            end

            if (w_en) begin
                r_s1_vld <= w_accept;
                if (w_accept) begin
                    r_s1_sum  <= {1'b0, i_z_data} + {1'b0, i_e_data};
                    r_s1_last <= w_cnt_last;
                end
                o_c_vld <= r_s1_vld;
                // Output data/last only refresh with a valid stage-1 entry, keeping idle outputs quiet.
                if (r_s1_vld) begin
                    o_c_data <= w_mod;
                    o_c_last <= r_s1_last;
                end else begin
                    o_c_last <= 1'b0;
                end
            end
        end
    end

endmodule
